core_seq_ctrl: RTL and testbench

- Autonomous sequencer that drives the systolic core through the full tiled flow: weight fill, kernel load, activation fill, execute, and output drain into psum memory.
- Sits between the activation/weight SRAM (xmem) and the core's control pins (L0, inst_w, ofifo, psum memory).
- Generalises the flow to runtime tile count and activation length.
- Adds multi-tile accumulation (acc) and final-tile ReLU, which the hand-sequenced flow lacks.

---
 rtl/core_pkg.sv | 32 +++
 rtl/core_seq_ctrl_xmem_rd_gen.sv | 74 +++++++
 rtl/core_seq_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_core_seq_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared types and encodings for the systolic core sequencer.
package core_pkg;

    // Sequencer phases, in the order a tile walks through them.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_W_FILL  = 3'd1,
        ST_W_LOAD  = 3'd2,
        ST_W_FLUSH = 3'd3,
        ST_A_FILL  = 3'd4,
        ST_EXEC    = 3'd5,
        ST_DRAIN   = 3'd6,
        ST_NEXT    = 3'd7
    } state_e;

    // Core instruction encodings driven on inst_w.
    localparam logic [1:0] INST_IDLE  = 2'b00;
    localparam logic [1:0] INST_KLOAD = 2'b01;
    localparam logic [1:0] INST_EXEC  = 2'b10;

    // Map a run-time count into 1..vmax: zero means one, oversize saturates.
    function automatic int unsigned cfg_clamp(input int unsigned v, input int unsigned vmax);
        if (v == 32'd0) begin
            return 32'd1;
        end else if (v > vmax) begin
            return vmax;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/core_seq_ctrl_xmem_rd_gen.sv
// Streams a run of xmem reads into L0: base/length load, stall on l0_full,
// and an l0_wr that trails each issued read by exactly one cycle.
module xmem_rd_gen
    import core_pkg::*;
#(
    parameter int XADDR_BW = 11,
    parameter int CNT_BW   = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [XADDR_BW-1:0] base,
    input  logic [CNT_BW-1:0]   len,
    input  logic                l0_full,
    output logic                xmem_cen,
    output logic [XADDR_BW-1:0] xmem_addr,
    output logic                l0_wr,
    output logic                busy
);

    logic [XADDR_BW-1:0] base_r;
    logic [XADDR_BW-1:0] addr_r;
    logic [CNT_BW-1:0]   remain_r;
    logic                pend_r;
    logic                active_r;
    logic                wr_r;
    logic                issue_s;

    // The read strobe must see l0_full in the same cycle, so xmem_cen is
    // the only combinational output; everything it drives downstream is registered.
    assign issue_s   = active_r & ~l0_full;
    assign xmem_cen  = ~issue_s;
    assign xmem_addr = addr_r;
    assign l0_wr     = wr_r;
    assign busy      = pend_r | active_r;

    // Address/count walker; a new base is only applied on a non-full cycle so the address never moves under l0_full.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            base_r   <= {XADDR_BW{1'b0}};
            addr_r   <= {XADDR_BW{1'b0}};
            remain_r <= {CNT_BW{1'b0}};
            pend_r   <= 1'b0;
            active_r <= 1'b0;
            wr_r     <= 1'b0;
        end else begin
            wr_r <= issue_s;
            if (load) begin
                base_r   <= base;
                remain_r <= (len == {CNT_BW{1'b0}}) ? CNT_BW'(1) : len;
                pend_r   <= 1'b1;
                active_r <= 1'b0;
            end else if (pend_r) begin
                if (!l0_full) begin
                    addr_r   <= base_r;
                    pend_r   <= 1'b0;
                    active_r <= 1'b1;
                end else begin
                    pend_r   <= 1'b1;
                end
            end else if (issue_s) begin
                remain_r <= remain_r - CNT_BW'(1);
                if (remain_r == CNT_BW'(1)) begin
                    active_r <= 1'b0;
                end else begin
                    addr_r <= addr_r + XADDR_BW'(1);
                end
            end else begin
                addr_r <= addr_r;
            end
        end
    end

endmodule

// File: rtl/core_seq_ctrl.sv
// Autonomous tile sequencer for the systolic core: weight fill, kernel load,
// flush, activation fill, execute and psum drain, repeated per tile with
// accumulation on later tiles and ReLU on the final one.
module core_seq_ctrl
    import core_pkg::*;
#(
    parameter int ROW      = 4,
    parameter int COL      = 4,
    parameter int LEN_MAX  = 8,
    parameter int TILE_MAX = 16,
    parameter int XADDR_BW = 11,
    parameter int PADDR_BW = 4,
    parameter int A_BASE   = 0,
    parameter int W_BASE   = 64
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [$clog2(TILE_MAX+1)-1:0]   cfg_tiles,
    input  logic [$clog2(LEN_MAX+1)-1:0]    cfg_len,
    output logic                            busy,
    output logic                            done,
    output logic                            xmem_cen,
    output logic [XADDR_BW-1:0]             xmem_addr,
    input  logic                            l0_full,
    output logic                            l0_wr,
    output logic                            l0_rd,
    output logic [1:0]                      inst_w,
    output logic                            mode,
    input  logic                            o_valid,
    output logic                            ofifo_rd,
    output logic                            pmem_wen,
    output logic [PADDR_BW-1:0]             pmem_addr,
    output logic                            acc,
    output logic                            relu
);

    localparam int TILE_BW = $clog2(TILE_MAX + 1);
    localparam int LEN_BW  = $clog2(LEN_MAX + 1);
    localparam int MAX_A   = (ROW > COL) ? ROW : COL;
    localparam int MAX_CNT = (MAX_A > LEN_MAX) ? MAX_A : LEN_MAX;
    localparam int CNT_BW  = $clog2(MAX_CNT + 1);

    state_e              state_r;
    logic [TILE_BW-1:0]  tiles_r;
    logic [TILE_BW-1:0]  tile_r;
    logic [LEN_BW-1:0]   len_r;
    logic [CNT_BW-1:0]   cnt_r;
    logic [PADDR_BW-1:0] row_r;
    logic                busy_r;
    logic                done_r;
    logic                l0_rd_r;
    logic                mode_r;
    logic [1:0]          inst_w_r;
    logic                ld_r;

    logic                last_tile_s;
    logic                drain_wr_s;
    logic [XADDR_BW-1:0] ld_base_s;
    logic [CNT_BW-1:0]   ld_len_s;
    logic                gen_busy_s;

    assign last_tile_s = (tile_r == (tiles_r - TILE_BW'(1)));
    assign drain_wr_s  = (state_r == ST_DRAIN) & o_valid;

    // Weight fills target this tile's ROW-deep slice; activation fills always start at A_BASE.
    assign ld_base_s = (state_r == ST_W_FILL)
                     ? (XADDR_BW'(W_BASE) + XADDR_BW'(tile_r) * XADDR_BW'(ROW))
                     : XADDR_BW'(A_BASE);
    assign ld_len_s  = (state_r == ST_W_FILL) ? CNT_BW'(ROW) : CNT_BW'(len_r);

    xmem_rd_gen #(
        .XADDR_BW (XADDR_BW),
        .CNT_BW   (CNT_BW)
    ) u_rd_gen (
        .clk       (clk),
        .reset     (reset),
        .load      (ld_r),
        .base      (ld_base_s),
        .len       (ld_len_s),
        .l0_full   (l0_full),
        .xmem_cen  (xmem_cen),
        .xmem_addr (xmem_addr),
        .l0_wr     (l0_wr),
        .busy      (gen_busy_s)
    );

    assign busy      = busy_r;
    assign done      = done_r;
    assign l0_rd     = l0_rd_r;
    assign inst_w    = inst_w_r;
    assign mode      = mode_r;
    assign pmem_addr = row_r;
    // Drain handshake follows o_valid directly so no ofifo row is missed.
    assign ofifo_rd  = drain_wr_s;
    assign pmem_wen  = drain_wr_s;
    assign acc       = drain_wr_s & (tile_r != {TILE_BW{1'b0}});
    assign relu      = drain_wr_s & last_tile_s;

    // Main tile sequencer; control outputs are registered alongside the state they belong to.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= ST_IDLE;
            tiles_r  <= {TILE_BW{1'b0}};
            tile_r   <= {TILE_BW{1'b0}};
            len_r    <= {LEN_BW{1'b0}};
            cnt_r    <= {CNT_BW{1'b0}};
            row_r    <= {PADDR_BW{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            l0_rd_r  <= 1'b0;
            mode_r   <= 1'b0;
            inst_w_r <= INST_IDLE;
            ld_r     <= 1'b0;
        end else begin
            ld_r   <= 1'b0;
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        tiles_r <= TILE_BW'(cfg_clamp(32'(cfg_tiles), 32'(TILE_MAX)));
                        len_r   <= LEN_BW'(cfg_clamp(32'(cfg_len), 32'(LEN_MAX)));
                        tile_r  <= {TILE_BW{1'b0}};
                        busy_r  <= 1'b1;
                        ld_r    <= 1'b1;
                        state_r <= ST_W_FILL;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                ST_W_FILL: begin
                    // Leaving one cycle after the last issue lets its l0_wr land first.
                    if (!ld_r && !gen_busy_s) begin
                        l0_rd_r  <= 1'b1;
                        inst_w_r <= INST_KLOAD;
                        mode_r   <= 1'b0;
                        cnt_r    <= {CNT_BW{1'b0}};
                        state_r  <= ST_W_LOAD;
                    end else begin
                        state_r  <= ST_W_FILL;
                    end
                end
                ST_W_LOAD: begin
                    if (cnt_r == CNT_BW'(ROW - 1)) begin
                        l0_rd_r  <= 1'b0;
                        inst_w_r <= INST_IDLE;
                        cnt_r    <= {CNT_BW{1'b0}};
                        state_r  <= ST_W_FLUSH;
                    end else begin
                        cnt_r    <= cnt_r + CNT_BW'(1);
                    end
                end
                ST_W_FLUSH: begin
                    if (cnt_r == CNT_BW'(COL - 1)) begin
                        cnt_r   <= {CNT_BW{1'b0}};
                        ld_r    <= 1'b1;
                        state_r <= ST_A_FILL;
                    end else begin
                        cnt_r   <= cnt_r + CNT_BW'(1);
                    end
                end
                ST_A_FILL: begin
                    if (!ld_r && !gen_busy_s) begin
                        l0_rd_r  <= 1'b1;
                        inst_w_r <= INST_EXEC;
                        mode_r   <= 1'b1;
                        cnt_r    <= {CNT_BW{1'b0}};
                        state_r  <= ST_EXEC;
                    end else begin
                        state_r  <= ST_A_FILL;
                    end
                end
                ST_EXEC: begin
                    if (cnt_r == (CNT_BW'(len_r) - CNT_BW'(1))) begin
                        l0_rd_r  <= 1'b0;
                        inst_w_r <= INST_IDLE;
                        mode_r   <= 1'b0;
                        cnt_r    <= {CNT_BW{1'b0}};
                        row_r    <= {PADDR_BW{1'b0}};
                        state_r  <= ST_DRAIN;
                    end else begin
                        cnt_r    <= cnt_r + CNT_BW'(1);
                    end
                end
                ST_DRAIN: begin
                    // No timeout: the drain simply waits for each o_valid.
                    if (o_valid) begin
                        if (row_r == (PADDR_BW'(len_r) - PADDR_BW'(1))) begin
                            row_r   <= {PADDR_BW{1'b0}};
                            state_r <= ST_NEXT;
                            if (last_tile_s) begin
                                done_r <= 1'b1;
                                busy_r <= 1'b0;
                            end else begin
                                done_r <= 1'b0;
                            end
                        end else begin
                            row_r <= row_r + PADDR_BW'(1);
                        end
                    end else begin
                        row_r <= row_r;
                    end
                end
                ST_NEXT: begin
                    if (last_tile_s) begin
                        state_r <= ST_IDLE;
                    end else begin
                        tile_r  <= tile_r + TILE_BW'(1);
                        ld_r    <= 1'b1;
                        state_r <= ST_W_FILL;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    busy_r   <= 1'b0;
                    l0_rd_r  <= 1'b0;
                    mode_r   <= 1'b0;
                    inst_w_r <= INST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Scoreboard bench for core_seq_ctrl: a run-level model pushes expected xmem
// reads, instruction bursts and psum writes; a monitor pops and compares.
module tb_core_seq_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic [4:0]  cfg_tiles;
    logic [3:0]  cfg_len;
    logic        busy, done, xmem_cen, l0_full, l0_wr, l0_rd, mode;
    logic [10:0] xmem_addr;
    logic [1:0]  inst_w;
    logic        o_valid, ofifo_rd, pmem_wen, acc, relu;
    logic [3:0]  pmem_addr;

    core_seq_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .cfg_tiles(cfg_tiles), .cfg_len(cfg_len),
        .busy(busy), .done(done), .xmem_cen(xmem_cen), .xmem_addr(xmem_addr),
        .l0_full(l0_full), .l0_wr(l0_wr), .l0_rd(l0_rd), .inst_w(inst_w), .mode(mode),
        .o_valid(o_valid), .ofifo_rd(ofifo_rd), .pmem_wen(pmem_wen), .pmem_addr(pmem_addr),
        .acc(acc), .relu(relu)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int exp_rd_q[$];
    int exp_wr_q[$];
    int exp_run_q[$];
    int exp_done   = 0;
    int done_seen  = 0;
    int l0wr_cnt   = 0;
    int cyc        = 0;
    int last_wr_cyc = -10;
    int cur_inst   = 0;
    int run_len    = 0;
    bit prev_issue = 1'b0;
    bit prev_full  = 1'b0;
    logic [10:0] prev_addr = 11'd0;
    bit mon_en     = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: compare DUT activity against the queued expectations.
    always @(negedge clk) begin
        if (mon_en) begin
            if (!xmem_cen) begin
                if (exp_rd_q.size() == 0) chk("rd_unexpected", int'(xmem_addr), -1);
                else chk("rd_addr", int'(xmem_addr), exp_rd_q.pop_front());
            end
            if (l0_full) chk("no_rd_when_full", int'(xmem_cen), 1);
            if (prev_full) chk("addr_hold", int'(xmem_addr), int'(prev_addr));
            chk("l0_wr_delay", int'(l0_wr), int'(prev_issue));
            if (l0_wr) l0wr_cnt++;
            chk("mode", int'(mode), int'(inst_w == 2'b10));
            if (int'(inst_w) != cur_inst) begin
                if (cur_inst != 0) begin
                    if (exp_run_q.size() == 0) chk("run_unexpected", cur_inst * 100 + run_len, -1);
                    else chk("inst_run", cur_inst * 100 + run_len, exp_run_q.pop_front());
                end
                cur_inst = int'(inst_w);
                run_len  = 0;
            end
            if (inst_w != 2'b00) run_len++;
            if (pmem_wen) begin
                chk("ofifo_rd", int'(ofifo_rd), 1);
                if (exp_wr_q.size() == 0) chk("wr_unexpected", int'(pmem_addr), -1);
                else chk("pmem_wr", int'(pmem_addr) * 4 + int'(acc) * 2 + int'(relu), exp_wr_q.pop_front());
                last_wr_cyc = cyc;
            end else begin
                chk("idle_wr_flags", int'({ofifo_rd, acc, relu}), 0);
            end
            if (done) begin
                done_seen++;
                chk("done_timing", cyc, last_wr_cyc + 1);
                chk("done_expected", exp_done, 1);
                if (exp_done > 0) exp_done--;
            end
            prev_issue = !xmem_cen;
            prev_full  = l0_full;
            prev_addr  = xmem_addr;
            cyc++;
        end
    end

    // Run-level reference: what a whole run must produce, independent of cycle timing.
    task automatic push_exp(input int t_cfg, input int l_cfg, output int n_wr);
        int T, L;
        T = (t_cfg == 0) ? 1 : ((t_cfg > 16) ? 16 : t_cfg);
        L = (l_cfg == 0) ? 1 : ((l_cfg > 8) ? 8 : l_cfg);
        for (int t = 0; t < T; t++) begin
            for (int i = 0; i < 4; i++) exp_rd_q.push_back(64 + t * 4 + i);
            exp_run_q.push_back(100 + 4);
            for (int i = 0; i < L; i++) exp_rd_q.push_back(i);
            exp_run_q.push_back(200 + L);
            for (int r = 0; r < L; r++)
                exp_wr_q.push_back(r * 4 + ((t != 0) ? 2 : 0) + ((t == T - 1) ? 1 : 0));
        end
        exp_done += 1;
        n_wr = T * (4 + L);
    endtask

    task automatic pulse_start(input int t_cfg, input int l_cfg);
        @(posedge clk); #2;
        start = 1'b1; cfg_tiles = 5'(t_cfg); cfg_len = 4'(l_cfg);
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    // ovm: 0 o_valid high, 1 random, 2 pattern 1,0,0,1. fullm: 0 none, 1 random, 2 one 3-cycle burst in A_FILL.
    task automatic run(input int t_cfg, input int l_cfg, input int ovm, input int fullm, input int spur);
        int n_wr, d0, w0, ph, burst;
        bit bdone;
        push_exp(t_cfg, l_cfg, n_wr);
        d0 = done_seen; w0 = l0wr_cnt; ph = 0; burst = 0; bdone = 1'b0;
        pulse_start(t_cfg, l_cfg);
        for (int c = 0; c < 6000 && done_seen == d0; c++) begin
            cfg_tiles = 5'($urandom_range(0, 31));
            cfg_len   = 4'($urandom_range(0, 15));
            case (ovm)
                0: o_valid = 1'b1;
                1: o_valid = 1'($urandom_range(0, 1));
                default: begin o_valid = ((ph % 4) == 0) || ((ph % 4) == 3); ph++; end
            endcase
            if (fullm == 1) begin
                l0_full = ($urandom_range(0, 4) == 0);
            end else if (fullm == 2) begin
                if (burst > 0) begin
                    l0_full = 1'b1; burst--;
                end else if (!bdone && !xmem_cen && xmem_addr == 11'd2) begin
                    l0_full = 1'b1; burst = 2; bdone = 1'b1;
                end else begin
                    l0_full = 1'b0;
                end
            end else begin
                l0_full = 1'b0;
            end
            start = (spur != 0) && busy && !done && ($urandom_range(0, 9) == 0);
            @(posedge clk); #2;
        end
        start = 1'b0; o_valid = 1'b0; l0_full = 1'b0;
        chk("run_done", done_seen - d0, 1);
        repeat (4) @(posedge clk);
        #2;
        chk("single_done", done_seen - d0, 1);
        chk("rd_left", exp_rd_q.size(), 0);
        chk("wr_left", exp_wr_q.size(), 0);
        chk("run_left", exp_run_q.size(), 0);
        chk("l0_wr_total", l0wr_cnt - w0, n_wr);
        chk("busy_after", int'(busy), 0);
        if (fullm == 2) chk("burst_hit", int'(bdone), 1);
    endtask

    task automatic reset_outputs(input string tag);
        chk({tag, "_cen"}, int'(xmem_cen), 1);
        chk({tag, "_addr"}, int'(xmem_addr), 0);
        chk({tag, "_ctl"}, int'({busy, done, l0_wr, l0_rd, mode, ofifo_rd, pmem_wen, acc, relu}), 0);
        chk({tag, "_inst"}, int'(inst_w), 0);
        chk({tag, "_paddr"}, int'(pmem_addr), 0);
    endtask

    // Abort a multi-tile run inside EXEC, then confirm it restarts from tile 0.
    task automatic reset_mid_exec();
        int n_wr;
        bit seen;
        push_exp(3, 5, n_wr);
        pulse_start(3, 5);
        seen = 1'b0;
        for (int c = 0; c < 2000 && !seen; c++) begin
            o_valid = 1'($urandom_range(0, 1));
            seen = (inst_w == 2'b10);
            if (!seen) begin @(posedge clk); #2; end
        end
        chk("reached_exec", int'(seen), 1);
        mon_en = 1'b0;
        reset = 1'b0;
        #1;
        reset_outputs("abort");
        exp_rd_q.delete(); exp_wr_q.delete(); exp_run_q.delete();
        exp_done = 0; cur_inst = 0; run_len = 0;
        prev_issue = 1'b0; prev_full = 1'b0; prev_addr = 11'd0;
        repeat (3) begin
            @(negedge clk);
            chk("no_done_in_reset", int'(done), 0);
        end
        @(posedge clk); #2;
        reset = 1'b1; o_valid = 1'b0;
        mon_en = 1'b1;
    endtask

    initial begin
        start = 1'b0; cfg_tiles = 5'd0; cfg_len = 4'd0; l0_full = 1'b0; o_valid = 1'b0;
        reset = 1'b1;
        #1 reset = 1'b0;
        #1 reset_outputs("reset");
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        mon_en = 1'b1;

        run(1, 8, 0, 0, 0);
        run(9, int'($urandom_range(1, 8)), 1, 1, 0);
        run(2, 8, 1, 2, 0);
        run(1, 8, 2, 0, 0);
        run(3, 4, 1, 1, 1);
        run(0, 0, 1, 0, 0);
        reset_mid_exec();
        run(2, 6, 1, 1, 0);
        for (int k = 0; k < 3; k++)
            run(int'($urandom_range(1, 5)), int'($urandom_range(1, 8)), 1, 1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
